pipeline_boot_ctrl: RTL
=======================

// Module: pipeline_boot_ctrl
// PURPOSE
// Boot/run controller for the pipelined datapath. Streams instruction and data images
// from a source ROM into imem/dmem while holding the core in reset, then releases it.
// Counts run cycles and detects the self-loop halt (jal x0,0). Reports done or timeout
// and freezes the core. Replaces fixed-delay preload-and-run sequencing with a
// parametrised, synthesizable sequencer.
// PARAMETERS
// DATA_W      32            word width of images and fetched instructions
// ADDR_W      6             word-address width of imem/dmem/source ROM
// IMEM_WORDS  41            words copied into imem (1..2**ADDR_W)
// DMEM_WORDS  5             words copied into dmem (0..2**ADDR_W)
// CNT_W       16            cycle counter width
// MAX_CYCLES  1000          run-cycle budget (1..2**CNT_W-1)
// HALT_INSTR  32'h0000006f  halt encoding (jal x0,0)
// HALT_REPEAT 3             consecutive halt fetches at one PC that declare halt (>=1)
// PORTS
// clk         in   1       clock, rising edge
// reset       in   1       asynchronous, active-low reset
// start       in   1       begin load+run; sampled only in IDLE or DONE
// src_sel     out  1       source region: 0 = imem image, 1 = dmem image
// src_rd_en   out  1       source ROM read strobe
// src_addr    out  ADDR_W  source ROM word address
// src_rdata   in   DATA_W  ROM data, valid the cycle after src_rd_en
// imem_we     out  1       imem write enable
// dmem_we     out  1       dmem write enable
// mem_waddr   out  ADDR_W  shared write address
// mem_wdata   out  DATA_W  shared write data
// core_rst_n  out  1       core reset, active-low
// core_stall  out  1       freezes the core pipeline (no state update)
// if_valid    in   1       fetch stage holds a valid instruction this cycle
// if_pc       in   32      fetch-stage PC
// if_instr    in   DATA_W  fetch-stage instruction
// busy        out  1       in LOAD_I, LOAD_D or RUN
// done        out  1       halt detected; sticky until next start or reset
// timeout     out  1       budget exhausted without halt; sticky
// cycle_count out  CNT_W   RUN cycles elapsed
// BEHAVIOUR
// - Reset (async assert, sync-clean deassert): state=IDLE.
//   All outputs 0, including core_rst_n=0, except core_stall=1.
// - FSM: IDLE -start-> LOAD_I -> LOAD_D (skipped if DMEM_WORDS==0) -> RUN -> DONE.
//   DONE -start-> LOAD_I.
// - LOAD_x: issue one read per cycle, src_addr 0..N-1, src_sel fixed for the region.
//   Write occurs one cycle after the read, mem_waddr = read addr, mem_wdata = src_rdata.
//   The exactly-one matching we is asserted.
//   The last write of LOAD_I overlaps the first read of LOAD_D (no bubble).
//   Total load = IMEM_WORDS+DMEM_WORDS+1 cycles.
// - core_rst_n=0 and core_stall=1 outside RUN. Entering RUN: core_rst_n=1, core_stall=0.
// - RUN: cycle_count increments every cycle from 0. It freezes on leaving RUN and
//   clears on start.
// - Halt tracking:
//   - A valid fetch with if_instr==HALT_INSTR and if_pc equal to the previous halt PC
//     increments a match counter. A halt fetch at a new PC sets the counter to 1.
//   - Any other valid fetch clears the counter. if_valid=0 cycles leave it unchanged.
//   - counter reaching HALT_REPEAT -> DONE with done=1, core_stall=1.
// - cycle_count==MAX_CYCLES-1 in RUN without halt -> DONE with timeout=1.
//   Halt in the same cycle wins: done=1, timeout=0.
// - busy = (state in LOAD_I, LOAD_D, RUN). done/timeout clear on the start cycle.
// - start while busy is ignored. Reset mid-load or mid-run aborts to IDLE immediately;
//   partially written memories are not cleaned up.
// TESTING
// - IMEM_WORDS=4, DMEM_WORDS=2, ROM imem={A0..A3} dmem={D0,D1}, pulse start ->
//   imem[0..3]=A0..A3, dmem[0..1]=D0,D1; core_rst_n rises exactly 7 cycles after start.
// - DMEM_WORDS=0 -> no dmem_we ever; RUN entered IMEM_WORDS+1 cycles after start.
// - RUN, fetch 0x0000006f at pc=0xA0 three valid cycles with one if_valid=0 gap ->
//   done=1 on the third fetch, cycle_count frozen, core_stall=1.
// - Halt fetches at pc 0xA0,0xA0 then 0xA4 -> counter restarts at 1, no done
//   until two more 0xA4 fetches.
// - MAX_CYCLES=20, no halt -> timeout=1 with cycle_count=19.
//   Halt forced on that same cycle -> done=1, timeout=0.
// - Drop reset during LOAD_D, release, start again -> full reload from addr 0;
//   start pulses during RUN ignored.

Source files
------------

// File: rtl/pipeline_boot_ctrl.sv
// Boot/run sequencer: copies imem/dmem images from a source ROM while the core is
// held in reset, then runs the core until a self-loop halt or the cycle budget ends.
module pipeline_boot_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 6,
    parameter int                IMEM_WORDS  = 41,
    parameter int                DMEM_WORDS  = 5,
    parameter int                CNT_W       = 16,
    parameter int                MAX_CYCLES  = 1000,
    parameter logic [DATA_W-1:0] HALT_INSTR  = 32'h0000006f,
    parameter int                HALT_REPEAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              src_sel,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_rdata,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst_n,
    output logic              core_stall,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic [DATA_W-1:0] if_instr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    // one extra bit so a full 2**ADDR_W image can be counted
    localparam int LDC_W = ADDR_W + 1;
    localparam int HC_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [LDC_W-1:0] I_N    = LDC_W'(IMEM_WORDS);
    localparam logic [LDC_W-1:0] D_N    = LDC_W'(DMEM_WORDS);
    // the final region spends one more cycle draining its last write
    localparam logic [LDC_W-1:0] I_END  = (DMEM_WORDS == 0) ? LDC_W'(IMEM_WORDS)
                                                            : LDC_W'(IMEM_WORDS - 1);
    localparam logic [LDC_W-1:0] D_END  = LDC_W'(DMEM_WORDS);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [HC_W-1:0]  HALT_N   = HC_W'(HALT_REPEAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              dmem;
        logic [ADDR_W-1:0] addr;
    } wr_req_t;

    state_t            state, state_nxt;
    logic [LDC_W-1:0]  ld_cnt;
    wr_req_t           wr;
    logic [CNT_W-1:0]  cyc;
    logic [HC_W-1:0]   hcnt;
    logic [HC_W-1:0]   hcnt_inc;
    logic [31:0]       hpc;
    logic              done_q, tmo_q;
    logic              rd_en, rd_sel, go;
    logic              halt_fetch, halt_hit, tmo_hit;

    always_comb begin
        halt_fetch = if_valid && (if_instr == HALT_INSTR);
        hcnt_inc   = (if_pc == hpc) ? (hcnt + HC_W'(1)) : HC_W'(1);
        halt_hit   = (state == S_RUN) && halt_fetch && (hcnt_inc == HALT_N);
        tmo_hit    = (state == S_RUN) && (cyc == CYC_LAST) && !halt_hit;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_sel    = 1'b0;
        go        = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = S_LOAD_I;
                end
            end
            S_LOAD_I: begin
                rd_en = (ld_cnt < I_N);
                if (ld_cnt == I_END)
                    state_nxt = (DMEM_WORDS == 0) ? S_RUN : S_LOAD_D;
            end
            S_LOAD_D: begin
                rd_en  = (ld_cnt < D_N);
                rd_sel = 1'b1;
                if (ld_cnt == D_END)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt_hit || tmo_hit)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ld_cnt <= '0;
            wr     <= '0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= (state_nxt != state) ? '0 : ld_cnt + LDC_W'(1);
            // the ROM answers one cycle later, so the write trails the read by one
            wr     <= '{vld: rd_en, dmem: rd_sel, addr: ld_cnt[ADDR_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc    <= '0;
            hcnt   <= '0;
            hpc    <= '0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (go) begin
            cyc    <= '0;
            hcnt   <= '0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (state == S_RUN) begin
            if (state_nxt == S_RUN)
                cyc <= cyc + CNT_W'(1);
            // bubbles keep the count; any other real fetch breaks the halt streak
            if (if_valid) begin
                hcnt <= halt_fetch ? hcnt_inc : '0;
                if (halt_fetch)
                    hpc <= if_pc;
            end
            if (halt_hit)
                done_q <= 1'b1;
            if (tmo_hit)
                tmo_q <= 1'b1;
        end
    end

    assign src_rd_en   = rd_en;
    assign src_sel     = rd_sel;
    assign src_addr    = rd_en ? ld_cnt[ADDR_W-1:0] : '0;
    assign imem_we     = wr.vld && !wr.dmem;
    assign dmem_we     = wr.vld && wr.dmem;
    assign mem_waddr   = wr.addr;
    assign mem_wdata   = wr.vld ? src_rdata : '0;
    assign core_rst_n  = (state == S_RUN);
    assign core_stall  = (state != S_RUN);
    assign busy        = (state == S_LOAD_I) || (state == S_LOAD_D) || (state == S_RUN);
    assign done        = done_q;
    assign timeout     = tmo_q;
    assign cycle_count = cyc;

endmodule
